// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the MIPS register file: WB has priority, MDU gets a stall after MAX_WAIT.
// Define RFARB_SCOREBOARD_EN to build the busy scoreboard; otherwise busy is tied low.
module regfile_wr_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_regWrite,
    input  logic [4:0]  wb_adr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_adr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_adr,
    output logic        stall_req,
    output logic [31:0] busy,
    output logic        rf_regWrite,
    output logic [4:0]  rf_writeAdr,
    output logic [31:0] rf_writeData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FORCE
    } state_t;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        stall_q, stall_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_adr_q, rf_adr_d;
    logic [31:0] rf_data_q, rf_data_d;

    logic wb_eff;
    logic xfer;
    logic blocked;

    assign wb_eff    = wb_regWrite && (wb_adr != 5'd0);
    assign mdu_ready = !rst && !wb_eff;
    assign xfer      = mdu_valid && mdu_ready;
    assign blocked   = mdu_valid && !mdu_ready;

    always_comb begin
        rf_we_d   = 1'b0;
        rf_adr_d  = 5'd0;
        rf_data_d = 32'd0;
        if (wb_eff) begin
            rf_we_d   = 1'b1;
            rf_adr_d  = wb_adr;
            rf_data_d = wb_data;
        end else if (xfer && (mdu_adr != 5'd0)) begin
            rf_we_d   = 1'b1;
            rf_adr_d  = mdu_adr;
            rf_data_d = mdu_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (blocked) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 4'd1;
                end
            end
            S_WAIT: begin
                if (!blocked) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 4'd0;
                end else if (wait_cnt_q >= MaxWait) begin
                    state_d = S_FORCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            S_FORCE: begin
                if (!blocked) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 4'd0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
        // Raise the stall in the same cycle the count saturates, one ahead of FORCE.
        stall_d = (state_d != S_IDLE) && (wait_cnt_d == MaxWait);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_adr_q   <= 5'd0;
            rf_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            rf_we_q    <= rf_we_d;
            rf_adr_q   <= rf_adr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign stall_req    = stall_q;
    assign rf_regWrite  = rf_we_q;
    assign rf_writeAdr  = rf_adr_q;
    assign rf_writeData = rf_data_q;

`ifdef RFARB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[mdu_adr] = 1'b0;
        end
        if (issue_valid && (issue_adr != 5'd0)) begin
            busy_d[issue_adr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_adr};
    assign busy = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed cases plus randomized traffic
// checked every cycle against a behavioural model of the arbitration rules.
module tb_regfile_wr_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_regWrite;
    logic [4:0]  wb_adr;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic [4:0]  mdu_adr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        issue_valid;
    logic [4:0]  issue_adr;
    logic        stall_req;
    logic [31:0] busy;
    logic        rf_regWrite;
    logic [4:0]  rf_writeAdr;
    logic [31:0] rf_writeData;

    regfile_wr_arbiter #(.MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_regWrite (wb_regWrite),
        .wb_adr      (wb_adr),
        .wb_data     (wb_data),
        .mdu_valid   (mdu_valid),
        .mdu_adr     (mdu_adr),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .issue_valid (issue_valid),
        .issue_adr   (issue_adr),
        .stall_req   (stall_req),
        .busy        (busy),
        .rf_regWrite (rf_regWrite),
        .rf_writeAdr (rf_writeAdr),
        .rf_writeData(rf_writeData)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: what the registered outputs must show after the last edge.
    logic        e_we;
    logic [4:0]  e_adr;
    logic [31:0] e_data;
    bit          e_known;
    logic        e_stall;
    logic [31:0] e_busy = 32'd0;
    int          run = 0;
    bit          m_xfer = 1'b0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit weff;
        bit blk;
        weff = wb_regWrite && (wb_adr != 5'd0);
        if (rst) begin
            e_we = 0; e_adr = 0; e_data = 0; e_known = 1;
            run = 0; e_stall = 0; e_busy = 0; m_xfer = 0;
        end else begin
            m_xfer  = mdu_valid && !weff;
            blk     = mdu_valid && weff;
            e_we    = 1;
            e_known = 1;
            if (weff) begin
                e_adr = wb_adr; e_data = wb_data;
            end else if (m_xfer && mdu_adr != 5'd0) begin
                e_adr = mdu_adr; e_data = mdu_data;
            end else begin
                e_we = 0; e_known = 0;
            end
            // Stall once the MDU has been refused MAX_WAIT cycles in a row.
            run     = blk ? run + 1 : 0;
            e_stall = (run >= MW);
`ifdef RFARB_SCOREBOARD_EN
            if (m_xfer) e_busy[mdu_adr] = 1'b0;
            if (issue_valid && issue_adr != 5'd0) e_busy[issue_adr] = 1'b1;
`endif
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdu_ready", {31'd0, mdu_ready},
                {31'd0, !rst && !(wb_regWrite && wb_adr != 5'd0)});
            chk("rf_regWrite", {31'd0, rf_regWrite}, {31'd0, e_we});
            if (e_known) begin
                chk("rf_writeAdr", {27'd0, rf_writeAdr}, {27'd0, e_adr});
                chk("rf_writeData", rf_writeData, e_data);
            end
            chk("stall_req", {31'd0, stall_req}, {31'd0, e_stall});
            chk("busy", busy, e_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic iv, input logic [4:0] ia);
        wb_regWrite = we; wb_adr = wa; wb_data = wd;
        mdu_valid = mv; mdu_adr = ma; mdu_data = md;
        issue_valid = iv; issue_adr = ia;
    endtask

    initial begin
        // Reset with both requesters active.
        rst = 1'b1;
        drive(1, 5, 32'hAA, 1, 6, 32'h1234, 1, 8);
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_we", {31'd0, rf_regWrite}, 32'd0);
        chk("rst_adr", {27'd0, rf_writeAdr}, 32'd0);
        chk("rst_data", rf_writeData, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ready", {31'd0, mdu_ready}, 32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post_rst_we", {31'd0, rf_regWrite}, 32'd0);

        // WB only.
        drive(1, 5, 32'h0000_00AA, 0, 0, 0, 0, 0);
        tick();
        chk("wb_we", {31'd0, rf_regWrite}, 32'd1);
        chk("wb_adr", {27'd0, rf_writeAdr}, 32'd5);
        chk("wb_data", rf_writeData, 32'hAA);

        // Conflict: WB r3 for two cycles, MDU r4 waits.
        drive(1, 3, 32'd7, 1, 4, 32'd9, 0, 0);
        tick();
        chk("cf1_adr", {27'd0, rf_writeAdr}, 32'd3);
        chk("cf1_data", rf_writeData, 32'd7);
        tick();
        chk("cf2_adr", {27'd0, rf_writeAdr}, 32'd3);
        drive(0, 0, 0, 1, 4, 32'd9, 0, 0);
        #1;
        chk("cf_ready", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk("cf3_we", {31'd0, rf_regWrite}, 32'd1);
        chk("cf3_adr", {27'd0, rf_writeAdr}, 32'd4);
        chk("cf3_data", rf_writeData, 32'd9);
        chk("cf_stall", {31'd0, stall_req}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Starvation: blocked in cycles 0..3, stall visible in cycle 4.
        drive(1, 2, 32'h55, 1, 6, 32'h1234, 0, 0);
        tick(); tick(); tick();
        chk("sv_stall3", {31'd0, stall_req}, 32'd0);
        tick();
        chk("sv_stall4", {31'd0, stall_req}, 32'd1);
        tick();
        chk("sv_stall5", {31'd0, stall_req}, 32'd1);
        drive(0, 0, 0, 1, 6, 32'h1234, 0, 0);
        tick();
        chk("sv_we", {31'd0, rf_regWrite}, 32'd1);
        chk("sv_adr", {27'd0, rf_writeAdr}, 32'd6);
        chk("sv_data", rf_writeData, 32'h1234);
        chk("sv_stall6", {31'd0, stall_req}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Scoreboard.
        drive(0, 0, 0, 0, 0, 0, 1, 8);
        tick();
`ifdef RFARB_SCOREBOARD_EN
        chk("sb_set8", {31'd0, busy[8]}, 32'd1);
        drive(0, 0, 0, 1, 8, 32'h88, 0, 0);
        tick();
        chk("sb_clr8", {31'd0, busy[8]}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        drive(0, 0, 0, 1, 9, 32'h99, 1, 9);
        tick();
        chk("sb_both9", {31'd0, busy[9]}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("sb_r0", busy, 32'h0000_0200);
`else
        chk("sb_off", busy, 32'd0);
`endif

        // WB to r0 never blocks the MDU.
        drive(1, 0, 32'hDEAD, 1, 7, 32'd1, 0, 0);
        #1;
        chk("r0_ready", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk("r0_we", {31'd0, rf_regWrite}, 32'd1);
        chk("r0_adr", {27'd0, rf_writeAdr}, 32'd7);
        chk("r0_data", rf_writeData, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Randomized traffic; the MDU holds its request until transfer.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (mdu_valid && m_xfer) mdu_valid = 1'b0;
            if (!mdu_valid && $urandom_range(0, 2) == 0) begin
                mdu_valid = 1'b1;
                mdu_adr   = 5'($urandom);
                mdu_data  = $urandom;
            end
            wb_regWrite = e_stall ? 1'b0 : ($urandom_range(0, 9) < 8);
            wb_adr      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            wb_data     = $urandom;
            issue_adr   = 5'($urandom);
            issue_valid = ($urandom_range(0, 2) == 0) && !e_busy[issue_adr];
            tick();
        end

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and scheduler for the 32x32 MIPS register file. It shares the file's single write port between the writeback stage and a multi-cycle multiply/divide unit (MDU). It guarantees forward progress for the MDU by requesting a pipeline stall after a bounded wait, and it keeps a busy scoreboard of registers with outstanding MDU results for the hazard unit. It sits between WB/MDU and the register file's write port (`regWrite`, `writeAdr`, `writeData`).

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive blocked MDU cycles before a stall is requested. Legal range is 1 to 15.

Ports:
- `clk`, input, 1: clock. Rising edge only.
- `rst`, input, 1: reset, synchronous, active-high.
- `wb_regWrite`, input, 1: WB stage write request. It has priority and no backpressure.
- `wb_adr`, input, 5: WB destination register.
- `wb_data`, input, 32: WB write data.
- `mdu_valid`, input, 1: MDU result pending.
- `mdu_adr`, input, 5: MDU destination register.
- `mdu_data`, input, 32: MDU result.
- `mdu_ready`, output, 1: the port is available to the MDU this cycle.
- `issue_valid`, input, 1: an MDU op is issued this cycle.
- `issue_adr`, input, 5: destination register of the issued MDU op.
- `stall_req`, output, 1: request to the pipeline to freeze WB.
- `busy`, output, 32: scoreboard, one bit per register.
- `rf_regWrite`, output, 1: to the register file `regWrite`.
- `rf_writeAdr`, output, 5: to the register file `writeAdr`.
- `rf_writeData`, output, 32: to the register file `writeData`.

## Operation
- **Effective WB write:** `wb_eff = wb_regWrite && wb_adr != 0`. A WB write to r0 never occupies the port.
- **MDU handshake:**
  - `mdu_ready = !rst && !wb_eff`. This is combinational.
  - A transfer occurs when `mdu_valid && mdu_ready`.
  - The MDU holds `mdu_valid`, `mdu_adr` and `mdu_data` stable until the transfer.
- **Port mux (registered):**
  - If `wb_eff`, the WB write is forwarded.
  - Else if an MDU transfer occurs with `mdu_adr != 0`, the MDU write is forwarded.
  - Else `rf_regWrite = 0`.
  - An MDU transfer to r0 is consumed with no write.
- **FSM:**
  - IDLE: enter WAIT when `mdu_valid && !mdu_ready`, and load `wait_cnt = 1`.
  - WAIT: while still blocked, increment `wait_cnt`. Move to FORCE when blocked and `wait_cnt == MAX_WAIT`. Move to IDLE on a transfer or when `mdu_valid` drops.
  - FORCE: `stall_req = 1`. Move to IDLE on a transfer or when `mdu_valid` drops.
  - `wait_cnt` is 4 bits and never wraps. It saturates at `MAX_WAIT`.
- **Scoreboard:**
  - `issue_valid` with `issue_adr != 0` sets `busy[issue_adr]`.
  - An MDU transfer clears `busy[mdu_adr]`.
  - If the same register is set and cleared in one cycle, the set wins.
  - `busy[0]` is always 0.
  - Issuing to an already-busy register is illegal. The hazard unit prevents it, and the bit stays set.
- **WB write to a busy register:** allowed. The port write proceeds and `busy` is unaffected.

## Timing
- **Reset values:** `rf_regWrite = 0`, `rf_writeAdr = 0`, `rf_writeData = 0`, `stall_req = 0`, `busy = 0`. FSM is in IDLE with `wait_cnt = 0`.
- **Reset mid-operation:** reset has priority over all other activity. Pending MDU state and scoreboard are dropped. `mdu_ready = 0` while `rst` is high.
- **Write latency:** a request in cycle N appears on `rf_*` in cycle N+1. The register file commits it at the end of N+1.
- **`mdu_ready`:** zero-latency with respect to `wb_regWrite` and `wb_adr`.
- **`stall_req`:** registered. With `MAX_WAIT = 4`, if the MDU is blocked in cycles 0 to 3, `stall_req` is 1 from cycle 4. It returns to 0 the cycle after the transfer.
- **Pipeline stall response:** the pipeline deasserts `wb_regWrite` no later than the cycle after `stall_req` rises.
- **`busy` update:** registered, visible the cycle after the issue or transfer.
- **Simultaneous WB and MDU:** WB always wins. The MDU waits with no data loss.

## Configuration
- **`RFARB_SCOREBOARD_EN` defined:** the scoreboard is built as described above.
- **`RFARB_SCOREBOARD_EN` undefined:**
  - `busy` is tied to 32'h0.
  - `issue_valid` and `issue_adr` are ignored.
  - No scoreboard flops are synthesized.
  - Arbitration and stall behaviour are unchanged.

## Test plan
- **Reset:** apply reset with `wb_regWrite=1` and `mdu_valid=1` -> all outputs 0 and `mdu_ready=0` throughout; no write on the first post-reset edge.
- **WB only:** WB write r5=0x0000_00AA in cycle N -> `rf_regWrite=1`, `rf_writeAdr=5`, `rf_writeData=0xAA` in N+1.
- **Conflict:** WB writes r3=7 while MDU holds r4=9 for 2 cycles, then WB goes idle -> r3 written first, then r4 written one cycle after WB idles; `stall_req` stays 0.
- **Starvation (`MAX_WAIT=4`):** WB continuous, MDU valid r6=0x1234 -> `stall_req`=1 at cycle 4; bench drops WB at cycle 5 -> transfer at 5, r6 written at 6, `stall_req`=0 at 6.
- **Scoreboard:**
  - Issue r8 -> `busy[8]`=1 the next cycle.
  - MDU transfer r8 -> `busy[8]`=0 the cycle after.
  - Issue r9 and transfer r9 in the same cycle -> `busy[9]` remains 1.
  - Issue r0 -> `busy` unchanged.
- **r0 writes:** WB write to r0 with MDU valid r7=1 in the same cycle -> MDU transfers that cycle; `rf_writeAdr`=7; r0 never written.
